processor_control_fsm: RTL

Multi-cycle control unit for the 8-bit application-specific processor. Fetches each instruction over a req/ack handshake, decodes it, and drives the immediate extractor select, ALU, register-file write enable and PC control through a fixed fetch/decode/execute/writeback sequence. Holds the architectural zero flag used by BRZ and counts retired instructions. Sits between instruction memory and the datapath; it contains no data registers other than the zero flag and the retire counter.

---
 rtl/processor_control_fsm.sv | 101 ++++++++++
 1 files changed

// File: rtl/processor_control_fsm.sv
// processor_control_fsm: multi-cycle fetch/decode/execute/writeback controller for the 8-bit processor
module processor_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ack,
  input  logic [7:0]       instruction,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_load,
  output logic [1:0]       imm_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             zero_flag,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;
  state_t state, state_nxt;
  logic [7:0] ir;
  logic [2:0] in_op, ir_op;
  logic [1:0] d_imm, d_alu;
  logic d_src, is_write, is_br, is_brz, is_rsv, take_br, shadow;
  assign in_op = instruction[7:5];
  assign ir_op = ir[7:5];
  // decode the incoming byte so the datapath selects are valid from the first DECODE cycle
  always_comb begin
    d_imm = (in_op == 3'b011 || in_op == 3'b100) ? 2'b10 :
            (in_op == 3'b101) ? 2'b11 :
            (in_op == 3'b110) ? 2'b01 : 2'b00;
    d_alu = (in_op == 3'b001) ? 2'b01 :
            (in_op == 3'b010 || in_op == 3'b101) ? 2'b10 :
            (in_op == 3'b110) ? 2'b11 : 2'b00;
    d_src = (in_op == 3'b000 || in_op == 3'b001 || in_op == 3'b010 || in_op == 3'b110);
  end
  // classify the latched instruction for the EXEC/WB actions
  always_comb begin
    is_br    = (ir_op == 3'b011);
    is_brz   = (ir_op == 3'b100);
    is_rsv   = (ir_op == 3'b111);
    is_write = !(is_br || is_brz || is_rsv);
    take_br  = is_br || (is_brz && zero_flag);
  end
  // next state and handshake/writeback pulses; pulses are masked during reset so no partial write escapes
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    reg_we    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    case (state)
      FETCH: begin
        ir_load   = imem_req && run && imem_ack && !reset;
        state_nxt = ir_load ? DECODE : FETCH;
      end
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = WB;
      default: begin
        state_nxt = FETCH;
        reg_we    = is_write && !reset;
        pc_load   = take_br && !reset;
        pc_inc    = !take_br && !reset;
      end
    endcase
  end
  // state, IR, decoded selects, zero flag with its EXEC shadow, sticky illegal and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      imem_req    <= 1'b0;
      ir          <= 8'h00;
      imm_sel     <= 2'b00;
      alu_op      <= 2'b00;
      alu_src_imm <= 1'b0;
      shadow      <= 1'b0;
      zero_flag   <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == FETCH) && run;
      if (ir_load) begin
        ir          <= instruction;
        imm_sel     <= d_imm;
        alu_op      <= d_alu;
        alu_src_imm <= d_src;
      end
      if (state == EXEC && is_write) shadow <= alu_zero;
      if (state == WB) begin
        retired <= retired + 1'b1;
        if (is_write) zero_flag <= shadow;
        if (is_rsv) illegal <= 1'b1;
      end
    end
  end
endmodule
